// File: rtl/window_serializer.sv
// Window FIFO plus shift-register serializer feeding one element per cycle to a MAC.
// Optional sticky drop flag on oOverflow is built only when WINSER_OVF_EN is defined.
module window_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int F          = 3,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        iValid,
    input  logic [DATA_WIDTH*F*F-1:0]   iData,
    output logic                        iReady,
    output logic                        oValid,
    input  logic                        oReady,
    output logic [DATA_WIDTH-1:0]       oData,
    output logic [$clog2(F*F)-1:0]      oIndex,
    output logic                        oLast,
    output logic                        oOverflow
);

    localparam int N  = F * F;
    localparam int WW = DATA_WIDTH * N;
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LASTIDX = IW'(N - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state, stateNext;
    logic [WW-1:0]   mem [DEPTH];
    logic [AW:0]     wrPtr, rdPtr;
    logic [WW-1:0]   shiftReg;
    logic [IW-1:0]   idx;
    logic            full, empty, push, pop, shift;

    assign full  = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
    assign empty = (wrPtr == rdPtr);
    assign push  = iValid && !full;

    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        shift     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    stateNext = SEND;
                end
            end
            SEND: begin
                if (oReady) begin
                    if (idx != LASTIDX) begin
                        shift = 1'b1;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wrPtr    <= '0;
            rdPtr    <= '0;
            shiftReg <= '0;
            idx      <= '0;
        end else begin
            state <= stateNext;
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) begin
                rdPtr    <= rdPtr + 1'b1;
                shiftReg <= mem[rdPtr[AW-1:0]];
                idx      <= '0;
            end else if (shift) begin
                shiftReg <= {shiftReg[WW-DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
                idx      <= idx + IW'(1);
            end else if (stateNext == IDLE) begin
                shiftReg <= '0;
                idx      <= '0;
            end
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr[AW-1:0]] <= iData;
    end

    assign iReady = !full;
    assign oValid = (state == SEND);
    assign oData  = (state == SEND) ? shiftReg[WW-1 -: DATA_WIDTH] : '0;
    assign oIndex = (state == SEND) ? idx : '0;
    assign oLast  = (state == SEND) && (idx == LASTIDX);

`ifdef WINSER_OVF_EN
    logic ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (iValid && full) begin
            ovf <= 1'b1;
        end
    end

    assign oOverflow = ovf;
`else
    assign oOverflow = 1'b0;
`endif

endmodule

// File: tb/tb_window_serializer.sv
// Self-checking bench for window_serializer: random windows against an element-queue model.
// Covers latency, back-to-back, backpressure, overflow, idle restart with wrap, mid-window reset.
module tb_window_serializer;

    localparam int DW = 16;
    localparam int N  = 9;
`ifdef WINSER_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              iValid = 1'b0;
    logic [DW*N-1:0]   iData = '0;
    logic              iReady;
    logic              oValid;
    logic              oReady = 1'b0;
    logic [DW-1:0]     oData;
    logic [3:0]        oIndex;
    logic              oLast;
    logic              oOverflow;

    window_serializer #(.DATA_WIDTH(DW), .F(3), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .iValid(iValid), .iData(iData), .iReady(iReady),
        .oValid(oValid), .oReady(oReady), .oData(oData),
        .oIndex(oIndex), .oLast(oLast), .oOverflow(oOverflow)
    );

    always #5 clk = ~clk;

    int tot = 0;
    int pass = 0;
    int cyc = 0;
    int holdViol = 0;
    logic heldV = 1'b0;
    logic [DW-1:0] heldD;
    logic [3:0] heldI;

    logic [DW-1:0] curE [N];
    logic [DW-1:0] expD [$];
    logic [DW-1:0] gotD [$];
    logic [3:0]    gotI [$];
    logic          gotL [$];
    int            gotCyc [$];

    task automatic clearQ();
        expD.delete(); gotD.delete(); gotI.delete(); gotL.delete(); gotCyc.delete();
        holdViol = 0;
        heldV = 1'b0;
    endtask

    // Build a window from a list of elements; element 0 ends up in the MSBs.
    task automatic mkWin(input int base, input bit rnd, output logic [DW*N-1:0] p);
        logic [DW-1:0] e;
        p = '0;
        for (int k = 0; k < N; k++) begin
            e = rnd ? DW'($urandom) : DW'(base + k);
            curE[k] = e;
            p = {p[DW*N-DW-1:0], e};
        end
    endtask

    task automatic commit();
        for (int k = 0; k < N; k++) expD.push_back(curE[k]);
    endtask

    // Drive one cycle from a negedge to the next; record handshakes and hold stability.
    task automatic step(input logic v, input logic [DW*N-1:0] d, input logic r, output bit acc);
        iValid = v; iData = d; oReady = r;
        acc = v && iReady;
        if (heldV && (oValid !== 1'b1 || oData !== heldD || oIndex !== heldI)) holdViol++;
        if (oValid && r) begin
            gotD.push_back(oData); gotI.push_back(oIndex);
            gotL.push_back(oLast); gotCyc.push_back(cyc);
        end
        heldV = oValid && !r; heldD = oData; heldI = oIndex;
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tot++; if (oValid !== 1'b0) $display("FAIL reset oValid got %b want 0", oValid); else pass++;
        tot++; if (oData !== '0) $display("FAIL reset oData got %h want 0", oData); else pass++;
        tot++; if (oIndex !== '0) $display("FAIL reset oIndex got %0d want 0", oIndex); else pass++;
        tot++; if (oLast !== 1'b0) $display("FAIL reset oLast got %b want 0", oLast); else pass++;
        tot++; if (oOverflow !== 1'b0) $display("FAIL reset oOverflow got %b want 0", oOverflow); else pass++;
        tot++; if (iReady !== 1'b1) $display("FAIL reset iReady got %b want 1", iReady); else pass++;
    endtask

    task automatic test_single();
        logic [DW*N-1:0] p;
        bit acc;
        clearQ();
        mkWin(1, 1'b0, p);
        step(1'b1, p, 1'b1, acc);
        tot++; if (acc !== 1'b1) $display("FAIL single push got %b want 1", acc); else begin pass++; commit(); end
        tot++; if (oValid !== 1'b0) $display("FAIL single lat1 oValid got %b want 0", oValid); else pass++;
        step(1'b0, '0, 1'b1, acc);
        tot++; if (oValid !== 1'b1 || oData !== 16'h0001 || oIndex !== 4'd0)
            $display("FAIL single lat2 got v=%b d=%h i=%0d want v=1 d=0001 i=0", oValid, oData, oIndex);
        else pass++;
        repeat (9) step(1'b0, '0, 1'b1, acc);
        tot++; if (gotD.size() != 9) $display("FAIL single count got %0d want 9", gotD.size()); else pass++;
        for (int k = 0; k < expD.size() && k < gotD.size(); k++) begin
            tot++;
            if (gotD[k] !== expD[k] || gotI[k] !== 4'(k % N) || gotL[k] !== (k % N == N - 1))
                $display("FAIL single elem%0d got %h/%0d/%b want %h/%0d/%b", k,
                         gotD[k], gotI[k], gotL[k], expD[k], k % N, k % N == N - 1);
            else pass++;
        end
        tot++; if (oValid !== 1'b0 || oData !== '0) $display("FAIL single idle got v=%b d=%h want 0/0", oValid, oData); else pass++;
    endtask

    task automatic test_back_to_back();
        logic [DW*N-1:0] p;
        bit acc;
        clearQ();
        for (int w = 0; w < 3; w++) begin
            mkWin(0, 1'b1, p);
            step(1'b1, p, 1'b1, acc);
            tot++; if (acc !== 1'b1) $display("FAIL b2b push%0d got %b want 1", w, acc); else begin pass++; commit(); end
        end
        repeat (40) step(1'b0, '0, 1'b1, acc);
        tot++; if (gotD.size() != 27) $display("FAIL b2b count got %0d want 27", gotD.size()); else pass++;
        if (gotD.size() == 27) begin
            tot++;
            if (gotCyc[26] - gotCyc[0] != 26) $display("FAIL b2b span got %0d want 26", gotCyc[26] - gotCyc[0]);
            else pass++;
        end
        for (int k = 0; k < expD.size() && k < gotD.size(); k++) begin
            tot++;
            if (gotD[k] !== expD[k] || gotI[k] !== 4'(k % N) || gotL[k] !== (k % N == N - 1))
                $display("FAIL b2b elem%0d got %h/%0d/%b want %h/%0d/%b", k,
                         gotD[k], gotI[k], gotL[k], expD[k], k % N, k % N == N - 1);
            else pass++;
        end
    endtask

    task automatic test_ready_pattern();
        logic [DW*N-1:0] p;
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit acc;
        clearQ();
        for (int w = 0; w < 2; w++) begin
            mkWin(0, 1'b1, p);
            step(1'b1, p, pat[cyc % 4], acc);
            if (acc) commit();
        end
        repeat (80) step(1'b0, '0, pat[cyc % 4], acc);
        tot++; if (holdViol != 0) $display("FAIL rdypat hold got %0d want 0", holdViol); else pass++;
        tot++; if (gotD.size() != 18) $display("FAIL rdypat count got %0d want 18", gotD.size()); else pass++;
        for (int k = 0; k < expD.size() && k < gotD.size(); k++) begin
            tot++;
            if (gotD[k] !== expD[k] || gotI[k] !== 4'(k % N) || gotL[k] !== (k % N == N - 1))
                $display("FAIL rdypat elem%0d got %h/%0d/%b want %h/%0d/%b", k,
                         gotD[k], gotI[k], gotL[k], expD[k], k % N, k % N == N - 1);
            else pass++;
        end
    endtask

    task automatic test_overflow();
        logic [DW*N-1:0] p;
        bit acc;
        bit got7;
        clearQ();
        for (int w = 0; w < 6; w++) begin
            mkWin(0, 1'b1, p);
            step(1'b1, p, 1'b0, acc);
            tot++;
            if (acc !== (w < 5)) $display("FAIL ovf accept%0d got %b want %b", w, acc, w < 5);
            else pass++;
            if (acc) commit();
        end
        tot++; if (iReady !== 1'b0) $display("FAIL ovf iReady got %b want 0", iReady); else pass++;
        tot++; if (oOverflow !== OVF_EXP) $display("FAIL ovf flag got %b want %b", oOverflow, OVF_EXP); else pass++;
        // Hold a 7th window while draining: only accepted once full clears before an edge.
        mkWin(0, 1'b1, p);
        got7 = 1'b0;
        for (int i = 0; i < 60 && !got7; i++) begin
            step(1'b1, p, 1'b1, acc);
            got7 = acc;
        end
        tot++; if (!got7) $display("FAIL ovf late push got 0 want 1"); else begin pass++; commit(); end
        repeat (80) step(1'b0, '0, 1'b1, acc);
        tot++; if (gotD.size() != 54) $display("FAIL ovf count got %0d want 54", gotD.size()); else pass++;
        for (int k = 0; k < expD.size() && k < gotD.size(); k++) begin
            tot++;
            if (gotD[k] !== expD[k] || gotI[k] !== 4'(k % N) || gotL[k] !== (k % N == N - 1))
                $display("FAIL ovf elem%0d got %h/%0d/%b want %h/%0d/%b", k,
                         gotD[k], gotI[k], gotL[k], expD[k], k % N, k % N == N - 1);
            else pass++;
        end
        tot++; if (oOverflow !== OVF_EXP) $display("FAIL ovf sticky got %b want %b", oOverflow, OVF_EXP); else pass++;
        tot++; if (iReady !== 1'b1 || oValid !== 1'b0) $display("FAIL ovf drained got r=%b v=%b want 1/0", iReady, oValid); else pass++;
    endtask

    task automatic test_wrap_idle();
        logic [DW*N-1:0] p;
        bit acc;
        clearQ();
        for (int w = 0; w < 8; w++) begin
            mkWin(0, 1'b1, p);
            if (w > 0) begin
                for (int i = 0; i < 20 && !(oValid && oLast); i++) step(1'b0, '0, 1'b1, acc);
            end
            step(1'b1, p, 1'b1, acc);
            tot++; if (acc !== 1'b1) $display("FAIL wrap push%0d got %b want 1", w, acc); else begin pass++; commit(); end
        end
        repeat (30) step(1'b0, '0, 1'b1, acc);
        tot++; if (gotD.size() != 72) $display("FAIL wrap count got %0d want 72", gotD.size()); else pass++;
        for (int b = 1; b < 8 && gotD.size() == 72; b++) begin
            tot++;
            if (gotCyc[9*b] - gotCyc[9*b-1] != 2)
                $display("FAIL wrap gap%0d got %0d want 2", b, gotCyc[9*b] - gotCyc[9*b-1]);
            else pass++;
        end
        for (int k = 0; k < expD.size() && k < gotD.size(); k++) begin
            tot++;
            if (gotD[k] !== expD[k] || gotI[k] !== 4'(k % N) || gotL[k] !== (k % N == N - 1))
                $display("FAIL wrap elem%0d got %h/%0d/%b want %h/%0d/%b", k,
                         gotD[k], gotI[k], gotL[k], expD[k], k % N, k % N == N - 1);
            else pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [DW*N-1:0] p;
        bit acc;
        clearQ();
        for (int w = 0; w < 2; w++) begin
            mkWin(0, 1'b1, p);
            step(1'b1, p, 1'b1, acc);
        end
        for (int i = 0; i < 20 && !(oValid && oIndex == 4'd4); i++) step(1'b0, '0, 1'b1, acc);
        tot++; if (oIndex !== 4'd4) $display("FAIL rstmid reach got %0d want 4", oIndex); else pass++;
        #2 rst_n = 1'b0;
        #1;
        tot++; if (oValid !== 1'b0 || oData !== '0 || oIndex !== '0 || oLast !== 1'b0 || oOverflow !== 1'b0 || iReady !== 1'b1)
            $display("FAIL rstmid outs got v=%b d=%h i=%0d l=%b o=%b r=%b want 0/0/0/0/0/1",
                     oValid, oData, oIndex, oLast, oOverflow, iReady);
        else pass++;
        @(negedge clk);
        rst_n = 1'b1;
        clearQ();
        mkWin(100, 1'b0, p);
        step(1'b1, p, 1'b1, acc);
        if (acc) commit();
        repeat (20) step(1'b0, '0, 1'b1, acc);
        tot++; if (gotD.size() != 9) $display("FAIL rstmid count got %0d want 9", gotD.size()); else pass++;
        for (int k = 0; k < expD.size() && k < gotD.size(); k++) begin
            tot++;
            if (gotD[k] !== expD[k] || gotI[k] !== 4'(k % N) || gotL[k] !== (k % N == N - 1))
                $display("FAIL rstmid elem%0d got %h/%0d/%b want %h/%0d/%b", k,
                         gotD[k], gotI[k], gotL[k], expD[k], k % N, k % N == N - 1);
            else pass++;
        end
    endtask

    task automatic test_random();
        logic [DW*N-1:0] p;
        bit acc;
        bit done;
        clearQ();
        for (int w = 0; w < 20; w++) begin
            mkWin(0, 1'b1, p);
            repeat ($urandom_range(0, 3)) step(1'b0, '0, $urandom_range(0, 3) != 0, acc);
            done = 1'b0;
            for (int i = 0; i < 200 && !done; i++) begin
                step(1'b1, p, $urandom_range(0, 3) != 0, acc);
                done = acc;
            end
            if (done) commit();
        end
        for (int i = 0; i < 400 && gotD.size() < expD.size(); i++)
            step(1'b0, '0, $urandom_range(0, 3) != 0, acc);
        tot++; if (holdViol != 0) $display("FAIL rand hold got %0d want 0", holdViol); else pass++;
        tot++; if (gotD.size() != 180) $display("FAIL rand count got %0d want 180", gotD.size()); else pass++;
        for (int k = 0; k < expD.size() && k < gotD.size(); k++) begin
            tot++;
            if (gotD[k] !== expD[k] || gotI[k] !== 4'(k % N) || gotL[k] !== (k % N == N - 1))
                $display("FAIL rand elem%0d got %h/%0d/%b want %h/%0d/%b", k,
                         gotD[k], gotI[k], gotL[k], expD[k], k % N, k % N == N - 1);
            else pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ready_pattern();
        test_wrap_idle();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end

endmodule
